// File: rtl/pulse_meter.sv
// pulse_meter -- measures period and high time of an asynchronous pulse input.
//
// The input pin is synchronized, de-glitched and then timed against clk_100mhz.
// Each accepted rising edge closes one period. From the second edge after
// arming, the period and the high time that belongs to it are published
// together. If no rising edge arrives for TIMEOUT cycles, signal loss is
// reported and the published values are cleared.
//
// Ports
//   clk_100mhz  in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   sig_in      in   asynchronous external pulse signal
//   level       out  filtered, synchronized input level
//   rise_stb    out  one-cycle pulse on each accepted rising edge
//   period      out  last complete period in clk_100mhz cycles
//   high_len    out  high time belonging to the published period
//   meas_stb    out  one-cycle pulse when period/high_len update
//   meas_valid  out  period/high_len hold a valid measurement
//   timeout     out  one-cycle pulse on signal-loss detection
module pulse_meter #(
    parameter int CNT_W      = 32,
    parameter int GLITCH_LEN = 3,
    parameter int TIMEOUT    = 100000000
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             level,
    output logic             rise_stb,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_len,
    output logic             meas_stb,
    output logic             meas_valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       FILT_LAST   = 4'(GLITCH_LEN - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [2:0]       sync_q;
    logic             sync_in;
    logic [3:0]       filt_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] high_pend;
    state_t           state;

    logic filt_accept;
    logic rise_now;
    logic fall_now;
    logic timeout_now;

    assign sync_in = sync_q[2];

    // NOTE: every signal driven here gets a default first so no latch can be
    // inferred when a later condition leaves it unassigned.
    always_comb begin
        filt_accept = 1'b0;
        rise_now    = 1'b0;
        fall_now    = 1'b0;
        timeout_now = 1'b0;
        // The filter has already seen GLITCH_LEN-1 differing cycles; this is
        // the last one, so the new level is taken on this edge.
        filt_accept = (sync_in != level) && (filt_cnt == FILT_LAST);
        rise_now    = filt_accept && sync_in;
        fall_now    = filt_accept && !sync_in;
        // A rising edge in the same cycle wins over loss detection.
        timeout_now = (state != IDLE) && !rise_now && (period_cnt == TIMEOUT_CNT);
    end

    // Three-flop synchronizer for the asynchronous pin.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], sig_in};
        end
    end

    // Glitch filter: any cycle agreeing with the current level restarts the
    // count, so only an unbroken run of GLITCH_LEN differing cycles is taken.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= 4'd0;
            level    <= 1'b0;
            rise_stb <= 1'b0;
        end else begin
            rise_stb <= rise_now;
            if (sync_in == level) begin
                filt_cnt <= 4'd0;
            end else if (filt_accept) begin
                filt_cnt <= 4'd0;
                level    <= sync_in;
            end else begin
                filt_cnt <= filt_cnt + 4'd1;
            end
        end
    end

    // Period and high-time counters. Both restart at 1 on the accepted rising
    // edge and saturate rather than wrap. The period counter runs regardless of
    // level, which is what lets a stuck-high input still time out.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            high_pend  <= '0;
        end else begin
            if (rise_now) begin
                period_cnt <= CNT_ONE;
            end else if (period_cnt != '1) begin
                period_cnt <= period_cnt + CNT_ONE;
            end

            if (rise_now) begin
                high_cnt <= CNT_ONE;
            end else if (level && (high_cnt != '1)) begin
                high_cnt <= high_cnt + CNT_ONE;
            end

            // Hold the high time until the rising edge that closes the period.
            if (fall_now) begin
                high_pend <= high_cnt;
            end
        end
    end

    // Measurement state machine with registered outputs. period and high_len
    // are only ever written together, so they always describe one period.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            period     <= '0;
            high_len   <= '0;
            meas_stb   <= 1'b0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_stb <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise_now) begin
                        state <= ARMED;
                    end
                end
                ARMED, LOCKED: begin
                    if (rise_now) begin
                        state      <= LOCKED;
                        period     <= period_cnt;
                        high_len   <= high_pend;
                        meas_stb   <= 1'b1;
                        meas_valid <= 1'b1;
                    end else if (timeout_now) begin
                        state      <= IDLE;
                        period     <= '0;
                        high_len   <= '0;
                        meas_valid <= 1'b0;
                        timeout    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter -- self-checking bench for pulse_meter (CNT_W=16,
// GLITCH_LEN=3, TIMEOUT=1000).
//
// A reference model derives the expected outputs every cycle from the pin
// history: the level follows the synchronized pin once the last GLITCH_LEN
// synchronized samples all disagree with it, and period/high time come from
// the cycle numbers of accepted edges. A table of square waves with expected
// period/high_len values and hand-written sequences cover the corner cases;
// randomized run lengths follow.
module tb_pulse_meter;

    localparam int CNT_W      = 16;
    localparam int GLITCH_LEN = 3;
    localparam int TIMEOUT    = 1000;
    localparam int SYNC_DEPTH = 3;
    localparam int OUT_W      = 5 + 2 * CNT_W;

    logic             clk_100mhz = 1'b0;
    logic             rst_n;
    logic             sig_in;
    logic             level;
    logic             rise_stb;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_len;
    logic             meas_stb;
    logic             meas_valid;
    logic             timeout;

    pulse_meter #(
        .CNT_W      (CNT_W),
        .GLITCH_LEN (GLITCH_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .level      (level),
        .rise_stb   (rise_stb),
        .period     (period),
        .high_len   (high_len),
        .meas_stb   (meas_stb),
        .meas_valid (meas_valid),
        .timeout    (timeout)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic hist[$];      // hist[i] = pin value sampled i edges ago
    int   m_k;          // edge counter of the model
    logic m_level, m_rise, m_meas, m_valid, m_to;
    bit   m_armed;      // at least one accepted rise since reset / timeout
    int   m_period, m_high, m_pend, m_last_rise;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 8 + GLITCH_LEN; i++) hist.push_back(1'b0);
        m_level = 1'b0; m_rise = 1'b0; m_meas = 1'b0; m_valid = 1'b0; m_to = 1'b0;
        m_armed = 1'b0; m_period = 0; m_high = 0; m_pend = 0; m_last_rise = 0;
    endfunction

    function automatic void model_step(input logic p);
        bit toggle;
        hist.push_front(p);
        void'(hist.pop_back());
        m_k++;
        // The synchronized value used on this edge is the pin SYNC_DEPTH edges
        // back; the level flips when GLITCH_LEN such samples in a row disagree.
        toggle = 1'b1;
        for (int i = SYNC_DEPTH; i < SYNC_DEPTH + GLITCH_LEN; i++)
            if (hist[i] == m_level) toggle = 1'b0;
        m_rise = 1'b0; m_meas = 1'b0; m_to = 1'b0;
        if (toggle) m_level = !m_level;
        if (toggle && m_level) begin
            m_rise = 1'b1;
            if (m_armed) begin
                m_meas   = 1'b1;
                m_valid  = 1'b1;
                m_period = m_k - m_last_rise;
                m_high   = m_pend;
            end
            m_armed     = 1'b1;
            m_last_rise = m_k;
        end else if (m_armed && (m_k - m_last_rise == TIMEOUT)) begin
            m_to = 1'b1; m_valid = 1'b0; m_period = 0; m_high = 0; m_armed = 1'b0;
        end
        if (toggle && !m_level) m_pend = m_k - m_last_rise;
    endfunction

    function automatic logic [OUT_W-1:0] dut_outs();
        return {level, rise_stb, meas_stb, meas_valid, timeout, period, high_len};
    endfunction

    function automatic logic [OUT_W-1:0] model_outs();
        return {m_level, m_rise, m_meas, m_valid, m_to, CNT_W'(m_period), CNT_W'(m_high)};
    endfunction

    // ---------------- stimulus helpers ----------------
    int cyc = 0;
    int n_rise = 0, n_meas = 0, n_to = 0;
    int last_rise_cyc = 0, last_to_cyc = 0;

    // Called at a falling edge: drive the pin, clock once, compare everything.
    task automatic tick(input logic v);
        sig_in = v;
        @(posedge clk_100mhz);
        model_step(v);
        cyc++;
        @(negedge clk_100mhz);
        check($sformatf("cycle %0d", cyc), 64'(dut_outs()), 64'(model_outs()));
        if (rise_stb) begin n_rise++; last_rise_cyc = cyc; end
        if (meas_stb) n_meas++;
        if (timeout)  begin n_to++; last_to_cyc = cyc; end
    endtask

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_period;
        int exp_high;
    } vec_t;

    vec_t tbl[6];
    int   tbl_idx;

    // Checks a meas_stb seen while driving table entry e. The first one in an
    // entry closes the last period of the previous entry.
    task automatic tbl_obs(input int e);
        int ep, eh;
        if (meas_stb) begin
            if (e > 0 && tbl_idx == 0) begin
                ep = tbl[e-1].exp_period; eh = tbl[e-1].exp_high;
            end else begin
                ep = tbl[e].exp_period;   eh = tbl[e].exp_high;
            end
            check($sformatf("tbl%0d period", e), 64'(period), 64'(ep));
            check($sformatf("tbl%0d high_len", e), 64'(high_len), 64'(eh));
            check($sformatf("tbl%0d valid", e), 64'(meas_valid), 64'(1));
            tbl_idx++;
        end
    endtask

    initial begin
        int r0, m0, t0, first_meas_rise;
        logic v;

        tbl[0] = '{hi: 40,  lo: 60,  reps: 5, exp_period: 100,  exp_high: 40};
        tbl[1] = '{hi: 20,  lo: 40,  reps: 4, exp_period: 60,   exp_high: 20};
        tbl[2] = '{hi: 10,  lo: 20,  reps: 4, exp_period: 30,   exp_high: 10};
        tbl[3] = '{hi: 500, lo: 500, reps: 3, exp_period: 1000, exp_high: 500};
        tbl[4] = '{hi: 7,   lo: 993, reps: 3, exp_period: 1000, exp_high: 7};
        tbl[5] = '{hi: 3,   lo: 3,   reps: 6, exp_period: 6,    exp_high: 3};

        // Reset state.
        rst_n = 1'b0; sig_in = 1'b0; m_k = 0;
        model_reset();
        repeat (3) @(negedge clk_100mhz);
        check("reset_state", 64'(dut_outs()), 64'(0));
        rst_n = 1'b1;

        // Short glitch is ignored; a pulse of exactly GLITCH_LEN is accepted
        // 6 cycles after the pin edge.
        repeat (10) tick(1'b0);
        r0 = n_rise;
        repeat (2) tick(1'b1);
        repeat (20) tick(1'b0);
        check("glitch_no_rise", 64'(n_rise - r0), 64'(0));
        check("glitch_level", 64'(level), 64'(0));
        t0 = cyc;
        repeat (3) tick(1'b1);
        for (int i = 0; i < 20 && n_rise == r0; i++) tick(1'b0);
        check("pulse_accepted", 64'(n_rise - r0), 64'(1));
        check("pulse_latency", 64'(last_rise_cyc - t0), 64'(6));

        // From ARMED, a held-low input times out and returns to IDLE.
        t0 = n_to;
        repeat (1100) tick(1'b0);
        check("armed_timeout", 64'(n_to - t0), 64'(1));

        // Table of square waves, including the rise landing exactly on count 1000.
        t0 = n_to;
        for (int e = 0; e < 6; e++) begin
            tbl_idx = 0;
            for (int r = 0; r < tbl[e].reps; r++) begin
                for (int h = 0; h < tbl[e].hi; h++) begin tick(1'b1); tbl_obs(e); end
                for (int l = 0; l < tbl[e].lo; l++) begin tick(1'b0); tbl_obs(e); end
            end
            check($sformatf("tbl%0d meas_count", e), 64'(tbl_idx),
                  64'((e == 0) ? tbl[e].reps - 1 : tbl[e].reps));
        end
        check("tbl_no_timeout", 64'(n_to - t0), 64'(0));

        // Held low after lock: timeout exactly TIMEOUT cycles after last rise_stb.
        t0 = n_to;
        for (int i = 0; i < 1500 && n_to == t0; i++) tick(1'b0);
        check("timeout_seen", 64'(n_to - t0), 64'(1));
        check("timeout_delay", 64'(last_to_cyc - last_rise_cyc), 64'(TIMEOUT));
        check("timeout_valid", 64'(meas_valid), 64'(0));
        check("timeout_period", 64'(period), 64'(0));
        check("timeout_high", 64'(high_len), 64'(0));

        // Resumed wave needs two rising edges before the first meas_stb.
        r0 = n_rise; m0 = n_meas; first_meas_rise = 0;
        for (int r = 0; r < 3; r++) begin
            for (int h = 0; h < 100; h++) begin
                tick((h < 40) ? 1'b1 : 1'b0);
                if (meas_stb && first_meas_rise == 0) first_meas_rise = n_rise - r0;
            end
        end
        check("resume_first_meas_rise", 64'(first_meas_rise), 64'(2));
        check("resume_meas_count", 64'(n_meas - m0), 64'(2));

        // Reset pulsed mid-period while the pin is high.
        repeat (20) tick(1'b1);
        #2 rst_n = 1'b0;
        #1 check("reset_async", 64'(dut_outs()), 64'(0));
        model_reset();
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
        rst_n = 1'b1;
        r0 = n_rise; m0 = n_meas;
        repeat (12) tick(1'b1);
        check("post_reset_rise", 64'(n_rise - r0), 64'(1));
        check("post_reset_no_meas", 64'(n_meas - m0), 64'(0));
        repeat (60) tick(1'b0);

        // Randomized run lengths: glitches, normal runs and near-timeout gaps.
        v = 1'b0;
        for (int s = 0; s < 80; s++) begin
            int sel, len;
            v   = !v;
            sel = $urandom_range(0, 9);
            if (sel < 2)      len = $urandom_range(1, GLITCH_LEN - 1);
            else if (sel < 8) len = $urandom_range(GLITCH_LEN, 150);
            else              len = $urandom_range(950, 1100);
            repeat (len) tick(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of all measurement counters and outputs.
REQ-002 SHALL have parameter GLITCH_LEN, default 3, number of consecutive stable cycles required to accept a level change (range 1..15).
REQ-003 SHALL have parameter TIMEOUT, default 100000000, cycle count without a rising edge that declares signal loss (2 .. 2^CNT_W-2).
REQ-004 SHALL have port clk_100mhz  input  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sig_in  input  1  asynchronous external pulse signal.
REQ-007 SHALL have port level  output  1  filtered, synchronized input level.
REQ-008 SHALL have port rise_stb  output  1  one-cycle pulse on each accepted rising edge.
REQ-009 SHALL have port period  output  CNT_W  last complete period in clk_100mhz cycles.
REQ-010 SHALL have port high_len  output  CNT_W  high time belonging to the published period, in cycles.
REQ-011 SHALL have port meas_stb  output  1  one-cycle pulse when period/high_len update.
REQ-012 SHALL have port meas_valid  output  1  period/high_len hold a valid measurement.
REQ-013 SHALL have port timeout  output  1  one-cycle pulse on signal-loss detection.

Function
REQ-014 SHALL pass sig_in through a 3-flop synchronizer before any other use.
REQ-015 SHALL change level only after the synchronized input has differed from level for GLITCH_LEN consecutive cycles; any shorter excursion resets the filter count and is ignored.
REQ-016 SHALL give a latency of exactly 3+GLITCH_LEN cycles from a clean sig_in transition to the level change; rise_stb asserts in the cycle level first reads 1.
REQ-017 SHALL implement states IDLE, ARMED and LOCKED; reset enters IDLE.
REQ-018 SHALL transition IDLE->ARMED on rise_stb, ARMED->LOCKED on the next rise_stb, and stay in LOCKED on each subsequent rise_stb.
REQ-019 SHALL keep the period counter so it loads 1 on the rise_stb cycle and increments by 1 each other cycle, saturating at all-ones.
REQ-020 SHALL keep the high counter so it loads 1 on the rise_stb cycle, increments while level=1, and is latched into a pending register on the cycle level falls.
REQ-021 SHALL, on a rise_stb while in ARMED or LOCKED, load period with the period counter value and high_len with the pending register in the same cycle, and assert meas_stb together with rise_stb.
REQ-022 SHALL make period and high_len update atomically and hold between meas_stb pulses.
REQ-023 SHALL set meas_valid on the first meas_stb and keep it set while in LOCKED.
REQ-024 SHALL, in ARMED or LOCKED, when the period counter reaches TIMEOUT with no rise_stb in that cycle: pulse timeout, clear meas_valid, zero period and high_len, and go to IDLE.
REQ-025 SHALL give rise_stb priority when rise_stb and the TIMEOUT count coincide: no timeout, normal measurement.
REQ-026 SHALL cover stuck-high inputs through REQ-024, since the period counter runs regardless of level.
REQ-027 SHALL never assert timeout in IDLE.
REQ-028 SHALL use widths exactly as declared, with no counter wrap-around.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force: synchronizer and filter to 0; level, rise_stb, meas_stb, meas_valid and timeout to 0; period, high_len and all counters to 0; state to IDLE.
REQ-030 SHALL treat the first accepted rising edge after reset release, including one asserted mid-period, as the ARMED edge with no meas_stb.

Verification (CNT_W=16, GLITCH_LEN=3, TIMEOUT=1000)
REQ-031 SHALL test a square wave of period 100 and high 40 -> first meas_stb on the 2nd rise_stb with period=100, high_len=40, meas_valid=1; repeats every 100 cycles.
REQ-032 SHALL test a 2-cycle high glitch on a low input -> level, rise_stb and counters unaffected; a 3-cycle pulse is accepted 6 cycles after the pin edge.
REQ-033 SHALL test input held low after lock -> timeout pulses exactly 1000 cycles after the last rise_stb, meas_valid=0, period=0; resumed wave needs 2 rising edges to produce meas_stb.
REQ-034 SHALL test a period change from 100 to 60 (high 20) while LOCKED -> the meas_stb after the first 60-cycle period reports period=60, high_len=20, with no intermediate values.
REQ-035 SHALL test rst_n pulsed low mid-period -> all outputs 0 in the same cycle; first edge after release gives rise_stb without meas_stb.
REQ-036 SHALL test a rising edge landing on the cycle the counter hits 1000 -> no timeout, period=1000, meas_stb=1.
